cascade_down_timer: RTL and testbench
=====================================

Name: cascade_down_timer

Overview:
Parametrised multi-digit BCD down-counter for the MS_Timer path. It generalises the fixed single-digit modulo counter into a chain of N digits, each with its own modulus. The default configuration is MM:SS, with moduli 10/6/10/10 from the least-significant digit up. It adds parallel load with clamping, hold-or-wrap at zero, and a one-cycle done pulse that feeds the microwave controller FSM.

Parameters:
NUM_DIGITS, 4, number of cascaded BCD digits (1..8).
DIGIT_MODS, {4'd10,4'd10,4'd6,4'd10}, packed 4-bit modulus per digit; digit 0 is the LSB field; each field must be 2..10.
HOLD_AT_ZERO, 1, 1 = stop at all-zero; 0 = wrap to the maximum value.

Ports:
clk  in  1  rising-edge clock.
clear  in  1  synchronous reset, active-low.
load  in  1  synchronous parallel load, active-low.
enab  in  1  count enable, active-high; decrements one step per edge.
numero  in  4*NUM_DIGITS  load value, BCD, digit i at bits [4i+3:4i].
numero_saida  out  4*NUM_DIGITS  current count, BCD, same packing.
tc_saida  out  1  terminal count (combinational) = enab & all digits zero & clear high.
zero_saida  out  1  all digits zero (combinational from state).
fim_saida  out  1  registered one-cycle done pulse.

Behaviour:
- Reset and edge priority:
  - Reset is synchronous and active-low.
  - Priority at each rising clk edge: clear low > load low > enab high > hold.
- Reset values:
  - Every digit is 0 and fim_saida is 0.
  - zero_saida reads 1 after reset.
  - tc_saida is forced 0 while clear is low.
- Load:
  - The cycle after an edge with load low, each digit equals numero digit i, clamped to DIGIT_MODS[i]-1 when that digit is >= its modulus.
  - Example: seconds-tens 4'h7 loads as 5.
  - Non-BCD codes (A-F) are clamped the same way.
  - Load overrides enab in the same cycle; no decrement happens.
  - Load does not generate fim_saida, even when loading zero.
- Count:
  - Digit i's enable = enab & (digits 0..i-1 all zero).
  - An enabled digit decrements; at 0 it wraps to DIGIT_MODS[i]-1.
  - Latency: one edge per step, and the result is visible after the edge.
- Zero boundary, HOLD_AT_ZERO=1:
  - All-zero with enab high holds at zero; no wrap.
  - tc_saida stays 1 while enab is high.
- Zero boundary, HOLD_AT_ZERO=0:
  - All-zero with enab high wraps every digit to its modulus-1 (default 99:59).
- fim_saida:
  - Set to 1 for exactly one cycle after an edge where a decrement takes the count from non-zero to all-zero.
  - Never set by clear, by load, or while holding at zero.
- enab low: state frozen and tc_saida is 0; zero_saida still reflects the state.
- clear asserted mid-count: the next edge zeroes all digits and clears any pending fim_saida.
- No combinational path from numero to any output.

Decomposition:
- Package timer_pkg holds:
  - DIGIT_W = 4;
  - the default MMSS moduli constant;
  - a clamp_digit(value, mod) function.
- One natural sub-module, mod_n_down_digit:
  - parameter MOD;
  - ports clk, clear, load, enab, numero[3:0], numero_saida[3:0], tc_saida, zero_saida.
  - Instantiated NUM_DIGITS times in a generate loop.
  - tc_saida of each digit is ANDed into the next digit's enab.
- The top level adds hold/wrap gating, the all-zero reduction and the fim register.

Test Plan:
1. Reset: clear low for 1 edge with enab=1, numero=16'h1234, load high -> numero_saida=16'h0000, zero_saida=1, tc_saida=0, fim_saida=0.
2. Load and cascade: load 16'h0102, then 3 enab edges -> 01:01, 01:00, 00:59; the digit-1 wrap goes to 5, not 9.
3. Clamp: load 16'h0A7C -> numero_saida=16'h0959.
4. Done and hold (HOLD_AT_ZERO=1): load 16'h0002, 2 enab edges -> 00:00; fim_saida=1 for exactly one cycle; a further 3 enab edges stay 00:00 with tc_saida=1 and fim_saida=0.
5. Wrap (HOLD_AT_ZERO=0 instance): from 00:00, 1 enab edge -> 16'h9959; fim_saida stays 0.
6. Simultaneous events:
   - load low + enab high with 16'h0030 -> 00:30, no decrement.
   - clear low during a count from 00:01, on the same edge that would reach zero -> 00:00 with fim_saida=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants and helpers for the cascaded BCD down-timer.
package timer_pkg;

  localparam int DIGIT_W = 4;

  // MM:SS moduli, least-significant digit in the low nibble.
  localparam logic [4*DIGIT_W-1:0] MMSS_MODS = {4'd10, 4'd10, 4'd6, 4'd10};

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] value,
    input logic [DIGIT_W-1:0] modulus
  );
    return (value >= modulus) ? modulus - DIGIT_W'(1) : value;
  endfunction

endpackage

// File: rtl/mod_n_down_digit.sv
// Single modulo-MOD down-counting digit with clamped load and cascade terminal count.
module mod_n_down_digit
  import timer_pkg::*;
#(
  parameter int unsigned MOD = 10
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               load,
  input  logic               enab,
  input  logic [DIGIT_W-1:0] numero,
  output logic [DIGIT_W-1:0] numero_saida,
  output logic               tc_saida,
  output logic               zero_saida
);

  localparam logic [DIGIT_W-1:0] MOD_V = DIGIT_W'(MOD);
  localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

  logic [DIGIT_W-1:0] r_cnt;
  logic               w_zero;

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_cnt <= '0;
    end else if (!load) begin
      r_cnt <= clamp_digit(numero, MOD_V);
    end else if (enab) begin
      r_cnt <= w_zero ? MAX_V : r_cnt - DIGIT_W'(1);
    end
  end

  assign w_zero       = (r_cnt == '0);
  assign numero_saida = r_cnt;
  assign zero_saida   = w_zero;
  assign tc_saida     = enab & w_zero & clear;

endmodule

// File: rtl/cascade_down_timer.sv
// N-digit cascaded BCD down-counter with clamped load, hold-or-wrap at zero and a done pulse.
module cascade_down_timer
  import timer_pkg::*;
#(
  parameter int                          NUM_DIGITS   = 4,
  parameter logic [4*NUM_DIGITS-1:0]     DIGIT_MODS   = MMSS_MODS,
  parameter bit                          HOLD_AT_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          clear,
  input  logic                          load,
  input  logic                          enab,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] numero,
  output logic [DIGIT_W*NUM_DIGITS-1:0] numero_saida,
  output logic                          tc_saida,
  output logic                          zero_saida,
  output logic                          fim_saida
);

  logic [NUM_DIGITS-1:0] w_en;
  logic [NUM_DIGITS-1:0] w_tc;
  logic [NUM_DIGITS-1:0] w_zero;
  logic                  w_all_zero;
  logic                  w_last_step;
  logic                  w_unused_tc;
  logic                  r_fim;

  assign w_all_zero = &w_zero;

  // Holding at zero simply starves the LSB of its enable; the carry chain does the rest.
  assign w_en[0] = enab & ~(HOLD_AT_ZERO & w_all_zero);

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_digit
      if (g > 0) begin : g_chain
        assign w_en[g] = w_tc[g-1];
      end
      mod_n_down_digit #(
        .MOD(int'(DIGIT_MODS[DIGIT_W*g +: DIGIT_W]))
      ) u_digit (
        .clk         (clk),
        .clear       (clear),
        .load        (load),
        .enab        (w_en[g]),
        .numero      (numero[DIGIT_W*g +: DIGIT_W]),
        .numero_saida(numero_saida[DIGIT_W*g +: DIGIT_W]),
        .tc_saida    (w_tc[g]),
        .zero_saida  (w_zero[g])
      );
    end
  endgenerate

  assign w_unused_tc = w_tc[NUM_DIGITS-1];

  // Only the value one step above zero reaches all-zero by decrementing.
  assign w_last_step = (numero_saida == (DIGIT_W*NUM_DIGITS)'(1));

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_fim <= 1'b0;
    end else begin
      r_fim <= load & enab & w_last_step;
    end
  end

  assign fim_saida  = r_fim;
  assign zero_saida = w_all_zero;
  assign tc_saida   = enab & w_all_zero & clear;

endmodule

// File: tb/tb_cascade_down_timer.sv
// Scoreboard bench for cascade_down_timer: hold and wrap instances against an integer-time model.
module tb_cascade_down_timer;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        load = 1'b1;
  logic        enab = 1'b0;
  logic [15:0] numero = '0;

  logic [15:0] h_cnt, w_cnt;
  logic        h_tc, h_zero, h_fim;
  logic        w_tc, w_zero, w_fim;

  always #5 clk = ~clk;

  cascade_down_timer #(.NUM_DIGITS(4), .HOLD_AT_ZERO(1'b1)) dut_hold (
    .clk(clk), .clear(clear), .load(load), .enab(enab), .numero(numero),
    .numero_saida(h_cnt), .tc_saida(h_tc), .zero_saida(h_zero), .fim_saida(h_fim)
  );

  cascade_down_timer #(.NUM_DIGITS(4), .HOLD_AT_ZERO(1'b0)) dut_wrap (
    .clk(clk), .clear(clear), .load(load), .enab(enab), .numero(numero),
    .numero_saida(w_cnt), .tc_saida(w_tc), .zero_saida(w_zero), .fim_saida(w_fim)
  );

  typedef struct {
    logic [15:0] cnt;
    logic        tc;
    logic        zero;
    logic        fim;
  } exp_t;

  exp_t qh[$];
  exp_t qw[$];

  int tests = 0;
  int fails = 0;

  // Model: the count is plain seconds-style integer time in mixed radix 10/6/10/10.
  localparam int MODS [4] = '{10, 6, 10, 10};
  localparam int MAXT = 5999;
  int  t_hold = 0, t_wrap = 0;
  bit  f_hold = 0, f_wrap = 0;

  function automatic int bcd_to_time(input logic [15:0] bcd);
    int v = 0;
    int wgt = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'(bcd[4*i +: 4]);
      if (d >= MODS[i]) d = MODS[i] - 1;
      v += d * wgt;
      wgt *= MODS[i];
    end
    return v;
  endfunction

  function automatic logic [15:0] time_to_bcd(input int t);
    logic [15:0] r = '0;
    int v = t;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % MODS[i]);
      v = v / MODS[i];
    end
    return r;
  endfunction

  task automatic model_step(inout int t, inout bit f, input bit hold);
    if (!clear) begin
      t = 0; f = 0;
    end else if (!load) begin
      t = bcd_to_time(numero); f = 0;
    end else if (enab) begin
      if (t == 0) begin
        t = hold ? 0 : MAXT; f = 0;
      end else begin
        t = t - 1; f = (t == 0);
      end
    end else begin
      f = 0;
    end
  endtask

  function automatic exp_t mk_exp(input int t, input bit f);
    exp_t e;
    e.cnt  = time_to_bcd(t);
    e.zero = (t == 0);
    e.tc   = enab & clear & (t == 0);
    e.fim  = f;
    return e;
  endfunction

  task automatic step(input bit c, input bit l, input bit e, input logic [15:0] n);
    @(negedge clk);
    clear = c; load = l; enab = e; numero = n;
    model_step(t_hold, f_hold, 1'b1);
    model_step(t_wrap, f_wrap, 1'b0);
    qh.push_back(mk_exp(t_hold, f_hold));
    qw.push_back(mk_exp(t_wrap, f_wrap));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh result after every edge that followed a stimulus step.
  always @(posedge clk) begin
    #1;
    if (qh.size() > 0 && qw.size() > 0) begin
      exp_t eh, ew;
      eh = qh.pop_front();
      ew = qw.pop_front();
      check("hold_cnt",  32'(h_cnt),  32'(eh.cnt));
      check("hold_zero", 32'(h_zero), 32'(eh.zero));
      check("hold_tc",   32'(h_tc),   32'(eh.tc));
      check("hold_fim",  32'(h_fim),  32'(eh.fim));
      check("wrap_cnt",  32'(w_cnt),  32'(ew.cnt));
      check("wrap_zero", 32'(w_zero), 32'(ew.zero));
      check("wrap_tc",   32'(w_tc),   32'(ew.tc));
      check("wrap_fim",  32'(w_fim),  32'(ew.fim));
    end
  end

  initial begin
    // Reset with enab high and junk on numero.
    step(1'b0, 1'b1, 1'b1, 16'h1234);
    // Load then cascade through the tens-of-seconds wrap.
    step(1'b1, 1'b0, 1'b0, 16'h0102);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 16'h0000);
    // Clamp of out-of-range and non-BCD digits.
    step(1'b1, 1'b0, 1'b0, 16'h0A7C);
    // Count to zero, then sit at zero (hold) / wrap (wrap instance).
    step(1'b1, 1'b0, 1'b0, 16'h0002);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    // Load of zero must not pulse done.
    step(1'b1, 1'b0, 1'b1, 16'h0000);
    // Load wins over enab.
    step(1'b1, 1'b0, 1'b1, 16'h0030);
    step(1'b1, 1'b1, 1'b0, 16'h0030);
    // Clear on the edge that would have reached zero.
    step(1'b1, 1'b0, 1'b0, 16'h0001);
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b1, 1'b1, 1'b1, 16'h0000);
    // Randomised traffic biased towards small loads so zero is reached often.
    for (int i = 0; i < 600; i++) begin
      logic [15:0] n;
      n = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 3) != 0), n);
    end
    repeat (2) @(negedge clk);
    check("drain_hold", 32'(qh.size()), 32'd0);
    check("drain_wrap", 32'(qw.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
